packetizer: RTL and testbench

Transmit-side framer for the mixed-modulation (MODE_MIX) link. It takes a byte stream over AXI-Stream and, on each symbol strobe from the modulator, emits one symbol of a packet: Barker preamble, then a 32-bit BPSK header, then the payload in BPSK or QPSK. The frame it produces is exactly what the receive-side depacketizer parses. It sits between the payload byte source and the PSK modulator, in the same clock domain.

---
 rtl/packetizer_if.sv | 21 ++
 rtl/packetizer.sv | 203 ++++++++++++++++++++
 tb/tb_packetizer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packetizer_if.sv
// Payload byte stream between the source and the packetizer (AXI-Stream subset).
interface packetizer_if;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready
  );
endinterface

// File: rtl/packetizer.sv
// Transmit framer: Barker preamble, 32-bit BPSK header, then BPSK or QPSK payload,
// one symbol per sampled sym_en; the sym_en after the last symbol retires the frame.
module packetizer #(
  parameter int unsigned PREAMBLE_REPS = 4,
  parameter logic [7:0]  SIGNATURE     = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [12:0]  pkt_len,
  input  logic [7:0]   pkt_mcs,
  packetizer_if.slave  axis,
  input  logic         sym_en,
  output logic         sym_valid,
  output logic [1:0]   sym_QPSK,
  output logic         sym_BPSK,
  output logic         is_bpsk,
  output logic         busy,
  output logic         done,
  output logic         err_underrun,
  output logic         err_len
);

  localparam logic [12:0] BARKER   = 13'b1111100110101;
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_REPS * 13 - 1);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    PRE  = 4'b0010,
    HDR  = 4'b0100,
    PLD  = 4'b1000
  } state_t;

  state_t      state;
  logic [7:0]  cnt_pre;
  logic [3:0]  chip_idx;
  logic [4:0]  cnt_hdr;
  logic [15:0] pld_left;
  logic [2:0]  sub_left;
  logic        fin;
  logic        hold_full;
  logic [12:0] acc_cnt;
  logic        tready;

  logic [12:0] len_q;
  logic        pld_bpsk;
  logic [31:0] hdr_sr;
  logic [7:0]  hold_data;
  logic [7:0]  sh;

  logic        hs;
  logic        step;
  logic        retire;
  logic        need_byte;
  logic        take;
  logic        pre_done;
  logic [7:0]  cur_byte;
  logic        hold_full_nxt;
  logic        in_hp_nxt;
  logic [12:0] acc_nxt;

  assign axis.s_axis_tready = tready;

  // fin marks "every symbol presented": the next sym_en only retires the frame
  assign hs        = axis.s_axis_tvalid && tready;
  assign step      = sym_en && (state != IDLE) && !fin;
  assign retire    = sym_en && (state != IDLE) && fin;
  assign need_byte = step && (state == PLD) && (sub_left == 3'd0);
  assign take      = need_byte && hold_full;
  assign pre_done  = step && (state == PRE) && (cnt_pre == PRE_LAST);

  // A byte landing on the same edge it is needed is too late; zeros go out instead
  assign cur_byte  = (sub_left != 3'd0) ? sh : (hold_full ? hold_data : 8'h00);

  assign hold_full_nxt = !retire && (hs || (hold_full && !take));
  assign acc_nxt       = acc_cnt + 13'(hs);
  assign in_hp_nxt     = pre_done || (((state == HDR) || (state == PLD)) && !retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt_pre      <= '0;
      chip_idx     <= '0;
      cnt_hdr      <= '0;
      pld_left     <= '0;
      sub_left     <= '0;
      fin          <= 1'b0;
      hold_full    <= 1'b0;
      acc_cnt      <= '0;
      tready       <= 1'b0;
      sym_valid    <= 1'b0;
      sym_QPSK     <= 2'b00;
      sym_BPSK     <= 1'b0;
      is_bpsk      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
      err_len      <= 1'b0;
    end else begin
      done      <= 1'b0;
      hold_full <= hold_full_nxt;
      acc_cnt   <= acc_nxt;
      tready    <= in_hp_nxt && !hold_full_nxt && (acc_nxt < len_q);

      if (hs && ((acc_cnt == len_q - 13'd1) != axis.s_axis_tlast))
        err_len <= 1'b1;
      if (need_byte && !hold_full)
        err_underrun <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state        <= PRE;
            busy         <= 1'b1;
            cnt_pre      <= '0;
            chip_idx     <= '0;
            cnt_hdr      <= '0;
            sub_left     <= '0;
            acc_cnt      <= '0;
            fin          <= 1'b0;
            err_underrun <= 1'b0;
            err_len      <= 1'b0;
          end
        end
        PRE: begin
          if (step) begin
            sym_valid <= 1'b1;
            is_bpsk   <= 1'b1;
            sym_BPSK  <= BARKER[4'd12 - chip_idx];
            sym_QPSK  <= {2{BARKER[4'd12 - chip_idx]}};
            cnt_pre   <= cnt_pre + 8'd1;
            chip_idx  <= (chip_idx == 4'd12) ? 4'd0 : chip_idx + 4'd1;
            if (pre_done)
              state <= HDR;
          end
        end
        HDR: begin
          if (step) begin
            sym_valid <= 1'b1;
            is_bpsk   <= 1'b1;
            sym_BPSK  <= hdr_sr[31];
            sym_QPSK  <= {2{hdr_sr[31]}};
            cnt_hdr   <= cnt_hdr + 5'd1;
            if (cnt_hdr == 5'd31) begin
              if (len_q != 13'd0) begin
                state    <= PLD;
                pld_left <= pld_bpsk ? {len_q, 3'b000} : {1'b0, len_q, 2'b00};
              end else begin
                fin <= 1'b1;
              end
            end
          end
        end
        PLD: begin
          if (step) begin
            sym_valid <= 1'b1;
            is_bpsk   <= pld_bpsk;
            sym_BPSK  <= cur_byte[7];
            sym_QPSK  <= pld_bpsk ? {2{cur_byte[7]}} : cur_byte[7:6];
            sub_left  <= (sub_left != 3'd0) ? sub_left - 3'd1 : (pld_bpsk ? 3'd7 : 3'd3);
            pld_left  <= pld_left - 16'd1;
            if (pld_left == 16'd1)
              fin <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (retire) begin
        state     <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b1;
        sym_valid <= 1'b0;
        sym_QPSK  <= 2'b00;
        sym_BPSK  <= 1'b0;
        is_bpsk   <= 1'b1;
        fin       <= 1'b0;
        cnt_pre   <= '0;
        chip_idx  <= '0;
        cnt_hdr   <= '0;
        pld_left  <= '0;
        sub_left  <= '0;
        acc_cnt   <= '0;
      end
    end
  end

  // Frame fields and byte shifters carry no reset; they are reloaded before use
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      len_q    <= pkt_len;
      pld_bpsk <= pkt_mcs[5];
      hdr_sr   <= {pkt_mcs, pkt_len, 3'b000, SIGNATURE};
    end
    if (step && (state == HDR))
      hdr_sr <= {hdr_sr[30:0], 1'b0};
    if (hs)
      hold_data <= axis.s_axis_tdata;
    if (step && (state == PLD))
      sh <= pld_bpsk ? {cur_byte[6:0], 1'b0} : {cur_byte[5:0], 2'b00};
  end

endmodule

// File: tb/tb_packetizer.sv
// Randomized frame bench for packetizer with a queue-based symbol model and literal spot checks.
module tb_packetizer;
  localparam int          REPS   = 2;
  localparam logic [7:0]  SIG    = 8'hA5;
  localparam logic [12:0] BARKER = 13'b1111100110101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sym_en = 1'b0;
  logic [12:0] pkt_len = '0;
  logic [7:0]  pkt_mcs = '0;
  logic        sym_valid, sym_BPSK, is_bpsk, busy, done, err_underrun, err_len;
  logic [1:0]  sym_QPSK;

  packetizer_if axis ();

  packetizer #(.PREAMBLE_REPS(REPS), .SIGNATURE(SIG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pkt_len(pkt_len), .pkt_mcs(pkt_mcs),
    .axis(axis), .sym_en(sym_en), .sym_valid(sym_valid), .sym_QPSK(sym_QPSK),
    .sym_BPSK(sym_BPSK), .is_bpsk(is_bpsk), .busy(busy), .done(done),
    .err_underrun(err_underrun), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic b; logic [1:0] q; } sym_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] pay [0:15];
  int src_n = 0, src_idx = 0, tlast_idx = -1, sym_mode = 1, done_seen = 0;

  sym_t expq [$];
  logic obs_b [$];
  logic [1:0] obs_q [$];
  logic obs_bit [$];
  logic m_busy = 1'b0, m_valid = 1'b0, m_exp_und = 1'b0, m_exp_len = 1'b0;
  int   m_len = 0;
  sym_t m_sym;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic sym_t mk(input logic b, input logic [1:0] q);
    sym_t s;
    s.b = b;
    s.q = q;
    return s;
  endfunction

  // Expected frame straight from the framing rules
  task automatic build_frame(input logic [12:0] len, input logic [7:0] mcs, input int nsrc, input int tl);
    logic [12:0] bk;
    logic [31:0] hdr;
    logic [7:0]  b;
    int ilen, sup;
    bk   = BARKER;
    ilen = int'(len);
    sup  = (nsrc < ilen) ? nsrc : ilen;
    expq.delete();
    for (int r = 0; r < REPS; r++)
      for (int c = 12; c >= 0; c--) expq.push_back(mk(1'b1, {2{bk[c]}}));
    hdr = {mcs, 16'(ilen * 8), SIG};
    for (int i = 31; i >= 0; i--) expq.push_back(mk(1'b1, {2{hdr[i]}}));
    for (int k = 0; k < ilen; k++) begin
      b = (k < sup) ? pay[k] : 8'h00;
      if (mcs[5])
        for (int i = 7; i >= 0; i--) expq.push_back(mk(1'b1, {2{b[i]}}));
      else
        for (int i = 3; i >= 0; i--) expq.push_back(mk(1'b0, 2'((b >> (2 * i)) & 8'd3)));
    end
    m_len     = ilen;
    m_exp_und = (sup < ilen);
    m_exp_len = 1'b0;
    for (int k = 0; k < sup; k++)
      if ((k == tl) != (k == ilen - 1)) m_exp_len = 1'b1;
  endtask

  initial begin : sym_drv
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph++;
      case (sym_mode)
        0:       sym_en = ($urandom_range(0, 1) == 1);
        1:       sym_en = 1'b1;
        default: sym_en = ((ph % sym_mode) == 0);
      endcase
    end
  end

  initial begin : src_drv
    logic pend;
    pend = 1'b0;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tdata  = 8'h00;
    axis.s_axis_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) src_idx++;
      if (src_idx < src_n) begin
        axis.s_axis_tvalid = 1'b1;
        axis.s_axis_tdata  = pay[src_idx];
        axis.s_axis_tlast  = (src_idx == tlast_idx);
      end else begin
        axis.s_axis_tvalid = 1'b0;
        axis.s_axis_tdata  = 8'h00;
        axis.s_axis_tlast  = 1'b0;
      end
      pend = axis.s_axis_tvalid && axis.s_axis_tready;
    end
  end

  initial begin : cmp
    logic st, se, rs, e_done;
    forever begin
      @(posedge clk);
      st = start;
      se = sym_en;
      rs = rst_n;
      #1;
      e_done = 1'b0;
      if (!rs) begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
        expq.delete();
      end else if (!m_busy) begin
        if (st) begin
          build_frame(pkt_len, pkt_mcs, src_n, tlast_idx);
          m_busy = 1'b1;
          obs_b.delete();
          obs_q.delete();
          obs_bit.delete();
          chk("err_clear_on_start", {err_underrun, err_len}, 2'b00);
        end
      end else if (se) begin
        if (expq.size() > 0) begin
          m_sym   = expq.pop_front();
          m_valid = 1'b1;
          obs_b.push_back(is_bpsk);
          obs_q.push_back(sym_QPSK);
          obs_bit.push_back(sym_BPSK);
        end else begin
          m_busy  = 1'b0;
          m_valid = 1'b0;
          e_done  = 1'b1;
          done_seen++;
          chk("err_flags_at_done", {err_underrun, err_len}, {m_exp_und, m_exp_len});
        end
      end
      chk("busy", busy, m_busy);
      chk("done", done, e_done);
      chk("sym_valid", sym_valid, m_valid);
      if (m_valid) begin
        chk("symbol", {is_bpsk, sym_QPSK}, {m_sym.b, m_sym.q});
        if (m_sym.b) chk("sym_BPSK", sym_BPSK, m_sym.q[0]);
      end
      if (!m_busy || m_len == 0) chk("tready_quiet", axis.s_axis_tready, 1'b0);
    end
  end

  function automatic logic [31:0] obs_bits(input int from, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], obs_bit[from + i]};
    return v;
  endfunction

  task automatic run_frame(input logic [12:0] len, input logic [7:0] mcs, input int nsrc,
                           input int tl, input int mode);
    int ds, n, expacc;
    @(negedge clk);
    src_idx   = 0;
    src_n     = nsrc;
    tlast_idx = tl;
    sym_mode  = mode;
    pkt_len   = len;
    pkt_mcs   = mcs;
    start     = 1'b1;
    ds        = done_seen;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done_seen == ds && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (done_seen == ds) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=%0d cycles required=done", n);
    end
    repeat (2) @(negedge clk);
    expacc = (nsrc < int'(len)) ? nsrc : int'(len);
    chk("bytes_accepted", src_idx, expacc);
    src_n = 0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cz;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outputs", {sym_valid, sym_QPSK, sym_BPSK, is_bpsk, busy, done},
        {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("rst_flags", {err_underrun, err_len, axis.s_axis_tready}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    pay[0] = 8'hA5;
    run_frame(13'd1, 8'h20, 1, 0, 1);
    chk("bpsk1_len", obs_bit.size(), REPS * 13 + 32 + 8);
    chk("bpsk1_barker", obs_bits(0, 13), 32'h1F35);
    chk("bpsk1_barker2", obs_bits(13, 13), 32'h1F35);
    chk("bpsk1_header", obs_bits(26, 32), 32'h200008A5);
    chk("bpsk1_payload", obs_bits(58, 8), 32'hA5);
    cz = 0;
    for (int i = 58; i < 66; i++) if (obs_b[i]) cz++;
    chk("bpsk1_is_bpsk", cz, 8);
    chk("bpsk1_flags", {err_underrun, err_len}, 2'b00);

    pay[0] = 8'h1B;
    pay[1] = 8'hE4;
    run_frame(13'd2, 8'h00, 2, 1, 4);
    chk("qpsk2_len", obs_q.size(), REPS * 13 + 32 + 8);
    chk("qpsk2_lenfield", obs_bits(34, 16), 32'h0010);
    begin
      logic [15:0] v;
      v = '0;
      for (int i = 58; i < 66; i++) v = {v[13:0], obs_q[i]};
      chk("qpsk2_payload", v, 16'h1BE4);
    end
    cz = 0;
    for (int i = 0; i < 66; i++) if (!obs_b[i]) cz++;
    chk("qpsk2_non_bpsk_count", cz, 8);
    chk("qpsk2_hdr_last_bpsk", obs_b[57], 1'b1);

    pay[0] = 8'h77;
    run_frame(13'd0, 8'h3C, 1, 0, 0);
    chk("zero_len", obs_bit.size(), REPS * 13 + 32);
    chk("zero_lenfield", obs_bits(34, 16), 32'h0000);

    pay[0] = 8'h3C;
    pay[1] = 8'hFF;
    run_frame(13'd2, 8'h20, 1, -1, 1);
    chk("underrun_len", obs_bit.size(), REPS * 13 + 32 + 16);
    chk("underrun_payload", obs_bits(58, 16), 32'h3C00);
    chk("underrun_flag", {err_underrun, err_len}, 2'b10);

    for (int k = 0; k < 4; k++) pay[k] = 8'(k * 37 + 5);
    run_frame(13'd3, 8'h20, 4, 1, 0);
    chk("early_tlast_flag", err_len, 1'b1);

    for (int f = 0; f < 12; f++) begin
      int len, tl, mode;
      len = $urandom_range(0, 6);
      for (int k = 0; k < 16; k++) pay[k] = 8'($urandom);
      tl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : len - 1;
      mode = (f % 3 == 0) ? 0 : ((f % 3 == 1) ? 1 : 3);
      run_frame(13'(len), 8'($urandom), len + 1, tl, mode);
    end

    // abort mid-header
    for (int k = 0; k < 16; k++) pay[k] = 8'($urandom);
    @(negedge clk);
    src_idx = 0; src_n = 5; tlast_idx = 3; sym_mode = 1;
    pkt_len = 13'd4; pkt_mcs = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {sym_valid, sym_QPSK, sym_BPSK, is_bpsk, busy, done},
        {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("abort_flags", {err_underrun, err_len, axis.s_axis_tready}, 3'b000);
    src_n = 0;
    src_idx = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cz = done_seen;
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_seen, cz);

    pay[0] = 8'hC3;
    pay[1] = 8'h5A;
    run_frame(13'd2, 8'h00, 3, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
